demux_stream_1ton: RTL and testbench

//  Registered 1-to-NUM_CH stream demultiplexer with per-channel valid/ready handshake.

---
 rtl/demux_pkg.sv | 17 +
 rtl/demux_out_slice.sv | 33 +++
 rtl/demux_stream_1ton.sv | 84 ++++++++
 tb/tb_demux_stream_1ton.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1-to-N stream demultiplexer.
package demux_pkg;

  // Channel index type, wide enough for up to 256 channels.
  // Per-instance selects are zero-extended into it.
  localparam int unsigned CH_IDX_W = 8;
  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  // Saturation value for the drop counter; sliced down to the counter width where used.
  localparam logic [63:0] DROP_SAT = '1;

  // A select is legal only when it names an existing channel.
  function automatic logic is_legal_sel(input ch_idx_t sel, input int unsigned num_ch);
    return 32'(sel) < num_ch;
  endfunction

endpackage

// File: rtl/demux_out_slice.sv
// One-entry output register slice with a valid/ready handshake on the consumer side.
module demux_out_slice #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Load wins over pop; data changes only on load, so it stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= data_in;
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;

endmodule

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-NUM_CH stream demultiplexer with unicast, broadcast and
// illegal-select drop counting.
module demux_stream_1ton
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_CH),
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WIDTH-1:0]        s_data,
  input  logic [SEL_W-1:0]        s_sel,
  input  logic                    s_bcast,
  output logic [NUM_CH-1:0]       m_valid,
  input  logic [NUM_CH-1:0]       m_ready,
  output logic [NUM_CH*WIDTH-1:0] m_data,
  output logic [CNT_W-1:0]        drop_cnt
);

  // Every select code gets an entry so the variable index never runs off the end.
  localparam int unsigned NUM_PAD = 1 << SEL_W;

  logic [NUM_CH-1:0]  w_can_acc;
  logic [NUM_PAD-1:0] w_can_acc_pad;
  logic [NUM_CH-1:0]  w_load;
  logic               w_sel_legal;
  logic               w_accept;
  logic               w_drop;
  logic [CNT_W-1:0]   r_drop_cnt;

  // A channel can take a beat when empty or when its current beat leaves this cycle.
  assign w_can_acc     = ~m_valid | m_ready;
  assign w_can_acc_pad = NUM_PAD'(w_can_acc);
  assign w_sel_legal   = is_legal_sel(ch_idx_t'(s_sel), NUM_CH);

  // Broadcast needs every channel free, unicast only its target; illegal selects are always taken.
  always_comb begin
    s_ready = 1'b0;
    if (rst_n) begin
      if (s_bcast) begin
        s_ready = &w_can_acc;
      end else if (w_sel_legal) begin
        s_ready = w_can_acc_pad[s_sel];
      end else begin
        s_ready = 1'b1;
      end
    end
  end

  assign w_accept = s_valid & s_ready;
  assign w_drop   = w_accept & ~s_bcast & ~w_sel_legal;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_load[i] = w_accept & (s_bcast | (s_sel == SEL_W'(i)));

    demux_out_slice #(
      .WIDTH(WIDTH)
    ) u_slice (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (w_load[i]),
      .data_in(s_data),
      .ready  (m_ready[i]),
      .valid  (m_valid[i]),
      .data   (m_data[i*WIDTH +: WIDTH])
    );
  end

  // Count beats consumed for a non-existent channel, holding at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != DROP_SAT[CNT_W-1:0])) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_demux_stream_1ton.sv
// Self-checking bench: queue-based channel model for the 4-channel instance plus
// directed literal checks, and two 3-channel instances for illegal-select dropping.
module tb_demux_stream_1ton;

  logic        clk;
  logic        rst_n;

  // 4-channel instance (power of two)
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic [1:0]  s_sel;
  logic        s_bcast;
  logic [3:0]  m_valid;
  logic [3:0]  m_ready;
  logic [31:0] m_data;
  logic [15:0] drop_cnt;

  // 3-channel instances share inputs; one with a 16-bit and one with a 2-bit drop counter
  logic        b_valid;
  logic [7:0]  b_data;
  logic [1:0]  b_sel;
  logic        b_bcast;
  logic [2:0]  b_mready;
  logic        b_sready;
  logic [2:0]  b_mvalid;
  logic [23:0] b_mdata;
  logic [15:0] b_drop;
  logic        c_sready;
  logic [2:0]  c_mvalid;
  logic [23:0] c_mdata;
  logic [1:0]  c_drop;

  int n_chk;
  int n_fail;
  logic cmp_en;

  demux_stream_1ton #(.WIDTH(8), .NUM_CH(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sel(s_sel), .s_bcast(s_bcast), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .drop_cnt(drop_cnt)
  );

  demux_stream_1ton #(.WIDTH(8), .NUM_CH(3), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(b_valid), .s_ready(b_sready), .s_data(b_data),
    .s_sel(b_sel), .s_bcast(b_bcast), .m_valid(b_mvalid), .m_ready(b_mready),
    .m_data(b_mdata), .drop_cnt(b_drop)
  );

  demux_stream_1ton #(.WIDTH(8), .NUM_CH(3), .CNT_W(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .s_valid(b_valid), .s_ready(c_sready), .s_data(b_data),
    .s_sel(b_sel), .s_bcast(b_bcast), .m_valid(c_mvalid), .m_ready(b_mready),
    .m_data(c_mdata), .drop_cnt(c_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model of the 4-channel instance ----------------
  // Each channel is a queue of beats waiting for its consumer, plus the last payload
  // delivered to it (the data lines keep showing it after the beat has left).
  logic [7:0]  mq[4][$];
  logic [7:0]  mdl_last[4];
  logic [15:0] mdl_drop;

  function automatic logic mdl_can(input int ch);
    return (mq[ch].size() == 0) || m_ready[ch];
  endfunction

  function automatic logic mdl_ready();
    if (!rst_n) return 1'b0;
    if (s_bcast) begin
      for (int c = 0; c < 4; c++) if (!mdl_can(c)) return 1'b0;
      return 1'b1;
    end
    return mdl_can(int'(s_sel));
  endfunction

  always @(posedge clk) begin
    logic acc;
    acc = s_valid && mdl_ready();
    if (!rst_n) begin
      for (int c = 0; c < 4; c++) begin
        mq[c].delete();
        mdl_last[c] = 8'h00;
      end
      mdl_drop = 16'h0;
    end else begin
      for (int c = 0; c < 4; c++) if (mq[c].size() != 0 && m_ready[c]) void'(mq[c].pop_front());
      if (acc) begin
        for (int c = 0; c < 4; c++) begin
          if (s_bcast || int'(s_sel) == c) begin
            mq[c].push_back(s_data);
            mdl_last[c] = s_data;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("mdl_valid[%0d]", c), 64'(m_valid[c]), 64'(mq[c].size() != 0));
        chk($sformatf("mdl_data[%0d]", c), 64'(m_data[c*8 +: 8]), 64'(mdl_last[c]));
      end
      chk("mdl_s_ready", 64'(s_ready), 64'(mdl_ready()));
      chk("mdl_drop_cnt", 64'(drop_cnt), 64'(mdl_drop));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [7:0] d, input logic [1:0] sel, input logic bc,
                     input logic [3:0] rdy);
    s_valid = v;
    s_data  = d;
    s_sel   = sel;
    s_bcast = bc;
    m_ready = rdy;
  endtask

  task automatic drvb(input logic v, input logic [7:0] d, input logic [1:0] sel,
                      input logic [2:0] rdy);
    b_valid  = v;
    b_data   = d;
    b_sel    = sel;
    b_bcast  = 1'b0;
    b_mready = rdy;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cmp_en = 1'b0;
    rst_n  = 1'b0;
    drv(1'b1, 8'hFF, 2'd0, 1'b0, 4'hF);
    drvb(1'b1, 8'hFF, 2'd3, 3'b111);

    // 1: reset held 3 cycles with s_valid high
    step();
    cmp_en = 1'b1;
    step();
    step();
    chk("rst_m_valid", 64'(m_valid), 64'h0);
    chk("rst_m_data", 64'(m_data), 64'h0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'h0);
    chk("rst_s_ready", 64'(s_ready), 64'h0);
    chk("rst_b_drop", 64'(b_drop), 64'h0);
    chk("rst_b_s_ready", 64'(b_sready), 64'h0);
    rst_n = 1'b1;
    drv(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
    drvb(1'b0, 8'h00, 2'd0, 3'b111);
    step();
    chk("post_rst_m_valid", 64'(m_valid), 64'h0);

    // 2: unicast to channel 2
    drv(1'b1, 8'hA5, 2'd2, 1'b0, 4'hF);
    #1 chk("uni_s_ready", 64'(s_ready), 64'h1);
    step();
    chk("uni_m_valid", 64'(m_valid), 64'h4);
    chk("uni_m_data", 64'(m_data), 64'h00A5_0000);
    drv(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
    step();
    chk("uni_drain_valid", 64'(m_valid), 64'h0);
    chk("uni_hold_data", 64'(m_data[23:16]), 64'hA5);

    // 3: backpressure on channel 1, other channel still flows, then pop+load with no bubble
    drv(1'b1, 8'h11, 2'd1, 1'b0, 4'b1101);
    step();
    chk("bp_load_valid", 64'(m_valid), 64'h2);
    drv(1'b1, 8'h55, 2'd1, 1'b0, 4'b1101);
    #1 chk("bp_stall_s_ready", 64'(s_ready), 64'h0);
    step();
    chk("bp_stall_data", 64'(m_data[15:8]), 64'h11);
    drv(1'b1, 8'h77, 2'd3, 1'b0, 4'b1101);
    #1 chk("bp_other_s_ready", 64'(s_ready), 64'h1);
    step();
    chk("bp_other_valid", 64'(m_valid), 64'hA);
    chk("bp_other_data", 64'(m_data[31:24]), 64'h77);
    drv(1'b1, 8'h22, 2'd1, 1'b0, 4'hF);
    #1 chk("bp_popload_s_ready", 64'(s_ready), 64'h1);
    step();
    chk("bp_popload_valid", 64'(m_valid), 64'h2);
    chk("bp_popload_data", 64'(m_data[15:8]), 64'h22);
    drv(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
    step();

    // 4: broadcast blocked by full channel 2, then lands on all channels together
    drv(1'b1, 8'h44, 2'd2, 1'b0, 4'b1011);
    step();
    drv(1'b1, 8'h3C, 2'd0, 1'b1, 4'b1011);
    #1 chk("bc_blocked_s_ready", 64'(s_ready), 64'h0);
    step();
    chk("bc_blocked_valid", 64'(m_valid), 64'h4);
    drv(1'b1, 8'h3C, 2'd0, 1'b1, 4'hF);
    #1 chk("bc_s_ready", 64'(s_ready), 64'h1);
    step();
    chk("bc_valid", 64'(m_valid), 64'hF);
    chk("bc_data", 64'(m_data), 64'h3C3C_3C3C);
    drv(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
    step();

    // 5: illegal select on 3-channel instances; 2-bit counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      drvb(1'b1, 8'(k), 2'd3, 3'b111);
      #1;
      chk("ill_b_s_ready", 64'(b_sready), 64'h1);
      chk("ill_c_s_ready", 64'(c_sready), 64'h1);
      step();
      chk("ill_b_no_valid", 64'(b_mvalid), 64'h0);
    end
    chk("ill_b_drop", 64'(b_drop), 64'd5);
    chk("ill_c_drop_sat", 64'(c_drop), 64'd3);
    chk("ill_c_no_valid", 64'(c_mvalid), 64'h0);
    drvb(1'b0, 8'h00, 2'd3, 3'b111);
    step();
    chk("ill_idle_drop", 64'(b_drop), 64'd5);
    drvb(1'b1, 8'h5A, 2'd2, 3'b111);
    step();
    chk("legal_b_valid", 64'(b_mvalid), 64'h4);
    chk("legal_b_data", 64'(b_mdata[23:16]), 64'h5A);
    drvb(1'b0, 8'h00, 2'd0, 3'b111);

    // Reset mid-operation discards pending beats and clears drop counters
    drv(1'b1, 8'h99, 2'd0, 1'b0, 4'b1110);
    step();
    chk("mid_pending_valid", 64'(m_valid), 64'h1);
    rst_n = 1'b0;
    drv(1'b1, 8'h66, 2'd1, 1'b0, 4'b1110);
    #1 chk("mid_rst_s_ready", 64'(s_ready), 64'h0);
    step();
    chk("mid_rst_valid", 64'(m_valid), 64'h0);
    chk("mid_rst_data", 64'(m_data), 64'h0);
    chk("mid_rst_b_drop", 64'(b_drop), 64'h0);
    chk("mid_rst_c_drop", 64'(c_drop), 64'h0);
    rst_n = 1'b1;
    #1 chk("mid_release_valid", 64'(m_valid), 64'h0);
    step();
    chk("mid_after_valid", 64'(m_valid), 64'h2);
    chk("mid_after_data", 64'(m_data[15:8]), 64'h66);
    drv(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
    step();

    // 6: random streaming against the model
    for (int k = 0; k < 1000; k++) begin
      drv(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom), 1'($urandom_range(0, 7) == 0),
          4'($urandom));
      step();
    end

    // Full throughput with every consumer ready
    for (int k = 0; k < 50; k++) begin
      drv(1'b1, 8'($urandom), 2'($urandom), 1'b0, 4'hF);
      #1 chk("thru_s_ready", 64'(s_ready), 64'h1);
      step();
    end
    drv(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
    step();
    chk("final_drain_valid", 64'(m_valid), 64'h0);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
